// File: rtl/task_responder_pkg.sv
// Shared types for the task responder: opcodes, FSM states and the request record.
package task_responder_pkg;

  localparam int REQ_W = 8;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2,
    OP_MUL = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef struct packed {
    op_e              op;
    logic [REQ_W-1:0] a;
    logic [REQ_W-1:0] b;
  } req_t;

endpackage

// File: rtl/task_responder_serial_mul.sv
// Unsigned shift-add multiplier, one multiplier bit per cycle, LSB first.
// The load cycle already folds in bit 0, so the product settles WIDTH-1 cycles after load.
module serial_mul #(
  parameter int WIDTH = 8
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               load,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               valid
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CNT_W-1:0]   r_cnt;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= CNT_W'(WIDTH - 1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Once the multiplier has shifted out, further steps leave the accumulator unchanged.
  always_ff @(posedge Clk) begin
    if (load) begin
      r_acc    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
      r_mcand  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
      r_mplier <= {1'b0, b[WIDTH-1:1]};
    end else begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

  assign product = r_acc;
  assign valid   = (r_cnt == '0);

endmodule

// File: rtl/task_responder.sv
// Target-side task engine: accepts NOP/ADD/SUB/MUL requests, runs them and
// returns Result with a Done pulse; one skid entry absorbs a back-to-back call.
module task_responder
  import task_responder_pkg::*;
#(
  parameter int WIDTH = REQ_W
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               Start,
  input  logic [1:0]         Op,
  input  logic [WIDTH-1:0]   OperandA,
  input  logic [WIDTH-1:0]   OperandB,
  output logic               Ready,
  output logic               Busy,
  output logic               Done,
  output logic [2*WIDTH-1:0] Result,
  output logic               Dropped
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_pend_vld;
  req_t               r_pend;
  req_t               r_cur;
  logic               r_busy;
  logic               r_done;
  logic               r_dropped;
  logic [2*WIDTH-1:0] r_result;

  state_e             w_state_nx;
  req_t               w_in_req;
  req_t               w_launch_req;
  logic               w_launch;
  logic               w_store;
  logic               w_accept;
  logic               w_exec_end;
  logic               w_mul_valid;
  logic [2*WIDTH-1:0] w_mul_product;

  function automatic logic [2*WIDTH-1:0] add_res(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    return {{(WIDTH-1){1'b0}}, ({1'b0, a} + {1'b0, b})};
  endfunction

  function automatic logic [2*WIDTH-1:0] sub_res(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    return {{WIDTH{1'b0}}, (a - b)};
  endfunction

  assign Ready    = ~r_pend_vld;
  assign w_accept = Start & ~r_pend_vld;
  assign w_in_req = '{op: op_e'(Op), a: OperandA, b: OperandB};

  assign w_exec_end = (r_state == S_EXEC) && (r_cnt == CNT_W'(1)) &&
                      ((r_cur.op != OP_MUL) || w_mul_valid);

  serial_mul #(.WIDTH(WIDTH)) u_mul (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .load    (w_launch),
    .a       (w_launch_req.a),
    .b       (w_launch_req.b),
    .product (w_mul_product),
    .valid   (w_mul_valid)
  );

  // A pending entry always wins over a fresh Start in DONE; Ready is low then anyway.
  always_comb begin
    w_state_nx   = r_state;
    w_launch     = 1'b0;
    w_store      = 1'b0;
    w_launch_req = w_in_req;
    case (r_state)
      S_IDLE: w_launch = w_accept;
      S_EXEC: begin
        w_store = w_accept;
        if (w_exec_end) w_state_nx = S_DONE;
      end
      S_DONE: begin
        if (r_pend_vld) begin
          w_launch     = 1'b1;
          w_launch_req = r_pend;
        end else if (w_accept) begin
          w_launch = 1'b1;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
    if (w_launch) w_state_nx = (w_launch_req.op == OP_NOP) ? S_DONE : S_EXEC;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_pend_vld <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_dropped  <= 1'b0;
      r_result   <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_busy    <= (w_state_nx != S_IDLE);
      r_done    <= (w_state_nx == S_DONE);
      r_dropped <= Start & r_pend_vld;
      if (w_launch) begin
        r_cnt <= (w_launch_req.op == OP_MUL) ? CNT_W'(WIDTH) : CNT_W'(1);
      end else if (r_state == S_EXEC) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_store) begin
        r_pend_vld <= 1'b1;
      end else if (r_state == S_DONE) begin
        r_pend_vld <= 1'b0;
      end
      if (w_exec_end) begin
        case (r_cur.op)
          OP_ADD:  r_result <= add_res(r_cur.a, r_cur.b);
          OP_SUB:  r_result <= sub_res(r_cur.a, r_cur.b);
          OP_MUL:  r_result <= w_mul_product;
          default: r_result <= r_result;
        endcase
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (w_launch) r_cur  <= w_launch_req;
    if (w_store)  r_pend <= w_in_req;
  end

  assign Busy    = r_busy;
  assign Done    = r_done;
  assign Dropped = r_dropped;
  assign Result  = r_result;

endmodule

// File: tb/tb_task_responder.sv
// Scoreboard bench for task_responder: a timing/result model built from job
// latencies predicts Done/Busy/Dropped/Ready; a monitor compares on every cycle.
module tb_task_responder;

  localparam int W = 8;

  logic           Clk = 1'b0;
  logic           Rst_n = 1'b0;
  logic           Start = 1'b0;
  logic [1:0]     Op = 2'd0;
  logic [W-1:0]   OperandA = '0;
  logic [W-1:0]   OperandB = '0;
  logic           Ready;
  logic           Busy;
  logic           Done;
  logic [2*W-1:0] Result;
  logic           Dropped;

  task_responder #(.WIDTH(W)) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .Start    (Start),
    .Op       (Op),
    .OperandA (OperandA),
    .OperandB (OperandB),
    .Ready    (Ready),
    .Busy     (Busy),
    .Done     (Done),
    .Result   (Result),
    .Dropped  (Dropped)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    int launch;
    int done_e;
    int res;
  } exp_t;

  exp_t q[$];
  int   dq[$];

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  // Model state: edge at which the engine becomes free, pending launch edge, last result
  int last_free = 0;
  int last_res  = 0;
  int pend_L    = 0;
  bit pend_vld  = 1'b0;
  bit mon_busy;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input bit st, input int op, input int a, input int b);
    int  e, lat, L, res;
    bit  rdy;
    @(negedge Clk);
    e   = cyc + 1;
    rdy = !(pend_vld && e <= pend_L);
    if (Rst_n) chk("ready", Ready, rdy);
    Start    = st;
    Op       = op[1:0];
    OperandA = a[W-1:0];
    OperandB = b[W-1:0];
    if (st && Rst_n) begin
      if (!rdy) begin
        dq.push_back(e);
      end else begin
        case (op)
          0:       lat = 1;
          3:       lat = W + 1;
          default: lat = 2;
        endcase
        L = (e > last_free) ? e : last_free;
        if (L > e) begin
          pend_vld = 1'b1;
          pend_L   = L;
        end
        case (op)
          0:       res = last_res;
          1:       res = (a & 255) + (b & 255);
          2:       res = ((a & 255) - (b & 255)) & 255;
          default: res = (a & 255) * (b & 255);
        endcase
        last_res  = res;
        last_free = L + lat;
        q.push_back('{L, L + lat - 1, res});
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 255)));
  endtask

  task automatic do_reset(input int hold);
    @(negedge Clk);
    #2;
    Rst_n = 1'b0;
    Start = 1'b0;
    #1;
    chk("rst_busy", Busy, 0);
    chk("rst_ready", Ready, 1);
    chk("rst_done", Done, 0);
    chk("rst_dropped", Dropped, 0);
    chk("rst_result", Result, 0);
    q.delete();
    dq.delete();
    pend_vld  = 1'b0;
    last_free = 0;
    last_res  = 0;
    repeat (hold) @(negedge Clk);
    #2;
    Rst_n = 1'b1;
  endtask

  initial begin
    forever begin
      @(negedge Clk);
      if (Rst_n) begin
        mon_busy = (q.size() > 0) && (q[0].launch <= cyc);
        chk("busy", Busy, mon_busy);
        if (Done) begin
          done_seen++;
          if (q.size() == 0) begin
            chk("done_unexpected", Done, 0);
          end else begin
            chk("done_cycle", cyc, q[0].done_e);
            chk("result", Result, q[0].res);
            void'(q.pop_front());
          end
        end else if (q.size() > 0 && q[0].done_e <= cyc) begin
          chk("done_missing", Done, 1);
          void'(q.pop_front());
        end
        if (Dropped) begin
          if (dq.size() == 0) begin
            chk("drop_unexpected", Dropped, 0);
          end else begin
            chk("drop_cycle", cyc, dq[0]);
            void'(dq.pop_front());
          end
        end else if (dq.size() > 0 && dq[0] <= cyc) begin
          chk("drop_missing", Dropped, 1);
          void'(dq.pop_front());
        end
      end
    end
  end

  initial begin
    int ds;
    do_reset(3);
    idle(2);

    drive(1'b1, 1, 200, 100);
    idle(4);
    chk("t1_add_result", Result, 16'h012C);

    drive(1'b1, 3, 255, 255);
    idle(12);
    chk("t2_mul_max", Result, 16'hFE01);
    drive(1'b1, 3, 0, 37);
    idle(12);
    chk("t2_mul_zero", Result, 16'h0000);

    drive(1'b1, 2, 5, 7);
    idle(4);
    chk("t3_sub_wrap", Result, 16'h00FE);
    drive(1'b1, 0, 11, 22);
    idle(3);
    chk("t3_nop_hold", Result, 16'h00FE);

    drive(1'b1, 3, 3, 4);
    idle(1);
    drive(1'b1, 1, 1, 1);
    idle(1);
    drive(1'b1, 2, 9, 2);
    idle(10);
    chk("t4_overlap_last", Result, 16'h0002);

    drive(1'b1, 3, 9, 9);
    idle(1);
    drive(1'b1, 1, 5, 6);
    idle(1);
    do_reset(2);
    ds = done_seen;
    idle(20);
    chk("t5_no_done_after_reset", done_seen - ds, 0);

    repeat (40) drive(1'b1, 1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    idle(6);

    repeat (400) drive($urandom_range(0, 2) == 0, int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    idle(25);
    chk("drain_results", q.size(), 0);
    chk("drain_drops", dq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout at cycle %0d: got running expected finished", cyc);
    $fatal(1, "timeout");
  end

endmodule
